accumulator_bank: RTL and testbench

Parametrised successor to the single-channel accumulator: a bank of `N` X-bit working registers for the NSC-8 datapath. It adds in-place register operations (nibble-immediate loads, increment/decrement, multi-cycle shifts, half swap), registered carry/zero flags and a busy/done handshake. Registers are read onto the shared data bus through a tristate output.

---
 rtl/accumulator_bank.sv | 176 +++++++++++++++++
 tb/tb_accumulator_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_bank.sv
// accumulator_bank: bank of N X-bit working registers with in-place operations,
// multi-cycle logical shifts, registered carry/zero flags and a tristate read port.
module accumulator_bank #(
  parameter int X = 8,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [X-1:0]           data_in,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic [2:0]             op,
  input  logic                   op_valid,
  input  logic [$clog2(X)-1:0]   shift_amount,
  input  logic [$clog2(N)-1:0]   out_sel,
  input  logic                   output_enable,
  output logic [X-1:0]           data_out,
  output logic                   busy,
  output logic                   op_done,
  output logic                   carry,
  output logic                   zero
);

  localparam int AW = $clog2(N);
  localparam int SW = $clog2(X);
  localparam int H  = X / 2;

  localparam logic [2:0] OpLoad   = 3'd0;
  localparam logic [2:0] OpLoadi  = 3'd1;
  localparam logic [2:0] OpLoadhi = 3'd2;
  localparam logic [2:0] OpInc    = 3'd3;
  localparam logic [2:0] OpDec    = 3'd4;
  localparam logic [2:0] OpShl    = 3'd5;
  localparam logic [2:0] OpShr    = 3'd6;
  localparam logic [2:0] OpSwap   = 3'd7;

  localparam logic StIdle  = 1'b0;
  localparam logic StShift = 1'b1;

  logic [X-1:0]  regs_q [N];
  logic [X-1:0]  regs_d [N];
  logic          state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic          dir_q, dir_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;

  logic [X-1:0]  selVal, tgtVal, outVal, result, shifted;
  logic          selOk, resCarry, shiftOut, isShift;

  // Index-matched read muxes; an index with no register behind it reads as 0.
  always_comb begin
    selVal = '0;
    tgtVal = '0;
    outVal = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == AW'(i))     selVal = regs_q[i];
      if (tgt_q == AW'(i))   tgtVal = regs_q[i];
      if (out_sel == AW'(i)) outVal = regs_q[i];
    end
  end

  assign selOk   = (int'(sel) < N);
  assign isShift = ((op == OpShl) || (op == OpShr)) && (shift_amount != '0);

  always_comb begin
    result   = selVal;
    resCarry = carry_q;
    case (op)
      OpLoad: begin
        result   = data_in;
        resCarry = 1'b0;
      end
      OpLoadi: begin
        result   = {{H{1'b0}}, data_in[H-1:0]};
        resCarry = 1'b0;
      end
      OpLoadhi: begin
        result   = {data_in[H-1:0], selVal[H-1:0]};
        resCarry = 1'b0;
      end
      OpInc: begin
        result   = selVal + X'(1);
        resCarry = &selVal;
      end
      OpDec: begin
        result   = selVal - X'(1);
        resCarry = ~|selVal;
      end
      OpSwap: begin
        result   = {selVal[H-1:0], selVal[X-1:H]};
        resCarry = 1'b0;
      end
      // zero-amount shifts leave the value and carry untouched
      default: ;
    endcase
  end

  assign shifted  = dir_q ? (tgtVal >> 1) : (tgtVal << 1);
  assign shiftOut = dir_q ? tgtVal[0] : tgtVal[X-1];

  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (op_valid) begin
          if (isShift && selOk) begin
            state_d = StShift;
            cnt_d   = shift_amount;
            tgt_d   = sel;
            dir_d   = (op == OpShr);
          end else begin
            done_d = 1'b1;
            if (selOk) begin
              for (int i = 0; i < N; i++) begin
                if (sel == AW'(i)) regs_d[i] = result;
              end
              carry_d = resCarry;
              zero_d  = (result == '0);
            end
          end
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          if (tgt_q == AW'(i)) regs_d[i] = shifted;
        end
        cnt_d = cnt_q - SW'(1);
        // flags reflect only the final step of the shift
        if (cnt_q == SW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          carry_d = shiftOut;
          zero_d  = (shifted == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q  <= '{default: '0};
      state_q <= StIdle;
      cnt_q   <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign data_out = output_enable ? outVal : {X{1'bz}};
  assign busy     = (state_q == StShift);
  assign op_done  = done_q;
  assign carry    = carry_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: table-driven and randomized checks of accumulator_bank
// against an arithmetic reference model of the register bank.
module tb_accumulator_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [1:0] sel;
  logic [2:0] op;
  logic       op_valid;
  logic [2:0] shift_amount;
  logic [1:0] out_sel;
  logic       output_enable;
  wire  [7:0] data_out;
  logic       busy, op_done, carry, zero;

  int compared   = 0;
  int mismatched = 0;

  int mreg [4];
  bit mcarry, mzero;

  typedef struct {
    int s;
    int o;
    int d;
    int a;
    int expVal;
    bit expCarry;
    bit expZero;
  } vec_t;
  vec_t vecs[$];

  accumulator_bank #(.X(8), .N(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .sel          (sel),
    .op           (op),
    .op_valid     (op_valid),
    .shift_amount (shift_amount),
    .out_sel      (out_sel),
    .output_enable(output_enable),
    .data_out     (data_out),
    .busy         (busy),
    .op_done      (op_done),
    .carry        (carry),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour expressed as plain integer arithmetic on the whole operation.
  function automatic void modelOp(input int s, input int o, input int d, input int a);
    int v = mreg[s];
    int r = v;
    bit c = mcarry;
    case (o)
      0: begin r = d & 255; c = 0; end
      1: begin r = d & 15; c = 0; end
      2: begin r = ((d & 15) << 4) | (v & 15); c = 0; end
      3: begin r = (v + 1) % 256; c = (v == 255); end
      4: begin r = (v + 255) % 256; c = (v == 0); end
      5: if (a != 0) begin r = (v << a) & 255; c = ((v >> (8 - a)) & 1) != 0; end
      6: if (a != 0) begin r = v >> a; c = ((v >> (a - 1)) & 1) != 0; end
      default: begin r = ((v & 15) << 4) | (v >> 4); c = 0; end
    endcase
    mreg[s] = r;
    mcarry  = c;
    mzero   = (r == 0);
  endfunction

  task automatic readReg(input int s, output logic [7:0] v);
    output_enable = 1'b1;
    out_sel = 2'(s);
    #1;
    v = data_out;
  endtask

  task automatic applyStimulus(input int s, input int o, input int d, input int a);
    int waited = 0;
    int lat;
    lat = ((o == 5 || o == 6) && a != 0) ? a : 0;
    @(negedge clk);
    sel = 2'(s);
    op = 3'(o);
    data_in = 8'(d);
    shift_amount = 3'(a);
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    while (!op_done && waited < 20) begin
      checkOutput("busyWhileWaiting", busy, 1);
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("doneLatency", waited, lat);
    checkOutput("busyWithDone", busy, 0);
    modelOp(s, o, d, a);
    @(posedge clk);
    #1;
    checkOutput("doneSinglePulse", op_done, 0);
  endtask

  function automatic void addVec(input int s, input int o, input int d, input int a,
                                 input int ev, input bit ec, input bit ez);
    vec_t v;
    v = '{s, o, d, a, ev, ec, ez};
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] rd;
    int s, o, d, a, r2;

    addVec(2, 0, 'hA5, 0, 'hA5, 0, 0);
    addVec(2, 1, 'h3C, 0, 'h0C, 0, 0);
    addVec(2, 2, 'h07, 0, 'h7C, 0, 0);
    addVec(2, 7, 'h00, 0, 'hC7, 0, 0);
    addVec(1, 0, 'hFF, 0, 'hFF, 0, 0);
    addVec(1, 3, 'h00, 0, 'h00, 1, 1);
    addVec(1, 4, 'h00, 0, 'hFF, 1, 0);
    addVec(1, 4, 'h00, 0, 'hFE, 0, 0);
    addVec(0, 0, 'h81, 0, 'h81, 0, 0);
    addVec(0, 5, 'h00, 3, 'h08, 0, 0);
    addVec(0, 0, 'hF8, 0, 'hF8, 0, 0);
    addVec(0, 6, 'h00, 4, 'h0F, 1, 0);
    addVec(3, 0, 'h55, 0, 'h55, 0, 0);
    addVec(1, 0, 'h00, 0, 'h00, 0, 1);
    addVec(1, 4, 'h00, 0, 'hFF, 1, 0);
    addVec(3, 5, 'h00, 0, 'h55, 1, 0);
    addVec(3, 0, 'h01, 0, 'h01, 0, 0);
    addVec(3, 6, 'h00, 1, 'h00, 1, 1);
    addVec(0, 0, 'hFF, 0, 'hFF, 0, 0);
    addVec(0, 5, 'h00, 7, 'h80, 1, 0);

    reset = 1'b1;
    data_in = '0;
    sel = '0;
    op = '0;
    op_valid = 1'b0;
    shift_amount = '0;
    out_sel = '0;
    output_enable = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    mcarry = 0;
    mzero = 1;
    repeat (2) @(negedge clk);
    checkOutput("resetBusZ", (data_out === 8'hzz), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      readReg(i, rd);
      checkOutput("resetReg", rd, 0);
    end
    checkOutput("resetZero", zero, 1);
    checkOutput("resetCarry", carry, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", op_done, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].o, vecs[i].d, vecs[i].a);
      readReg(vecs[i].s, rd);
      checkOutput("vecValue", rd, vecs[i].expVal);
      checkOutput("vecCarry", carry, vecs[i].expCarry);
      checkOutput("vecZero", zero, vecs[i].expZero);
    end

    // Cycle-by-cycle SHL with an ignored request while busy.
    applyStimulus(0, 0, 'h81, 0);
    out_sel = 2'd0;
    output_enable = 1'b1;
    @(negedge clk);
    sel = 2'd0;
    op = 3'd5;
    shift_amount = 3'd3;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    checkOutput("shlBusyE0", busy, 1);
    checkOutput("shlBusE0", data_out, 'h81);
    @(negedge clk);
    op = 3'd0;
    data_in = 8'h00;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    checkOutput("shlBusyE1", busy, 1);
    checkOutput("shlBusE1", data_out, 'h02);
    checkOutput("shlDoneE1", op_done, 0);
    @(posedge clk);
    #1;
    checkOutput("shlBusyE2", busy, 1);
    checkOutput("shlBusE2", data_out, 'h04);
    @(posedge clk);
    #1;
    checkOutput("shlBusyE3", busy, 0);
    checkOutput("shlBusE3", data_out, 'h08);
    checkOutput("shlDoneE3", op_done, 1);
    checkOutput("shlCarry", carry, 0);
    checkOutput("shlZero", zero, 0);
    @(posedge clk);
    #1;
    checkOutput("shlDoneE4", op_done, 0);
    checkOutput("shlBusE4", data_out, 'h08);
    @(posedge clk);
    #1;
    checkOutput("shlDoneE5", op_done, 0);
    modelOp(0, 5, 0, 3);

    for (int n = 0; n < 80; n++) begin
      s = $urandom_range(0, 3);
      o = $urandom_range(0, 7);
      d = $urandom_range(0, 255);
      a = $urandom_range(0, 7);
      r2 = $urandom_range(0, 3);
      applyStimulus(s, o, d, a);
      readReg(s, rd);
      checkOutput("randValue", rd, mreg[s]);
      checkOutput("randCarry", carry, mcarry);
      checkOutput("randZero", zero, mzero);
      readReg(r2, rd);
      checkOutput("randOther", rd, mreg[r2]);
    end

    // Reset during the second cycle of a 5-bit shift, bus kept disabled.
    applyStimulus(3, 0, 'h81, 0);
    output_enable = 1'b0;
    @(negedge clk);
    sel = 2'd3;
    op = 3'd5;
    shift_amount = 3'd5;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midBusyBefore", busy, 1);
    checkOutput("midBusZ", (data_out === 8'hzz), 1);
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDone", op_done, 0);
    checkOutput("midResetZero", zero, 1);
    checkOutput("midResetCarry", carry, 0);
    checkOutput("midResetBusZ", (data_out === 8'hzz), 1);
    @(negedge clk);
    reset = 1'b0;
    sel = 2'd1;
    op = 3'd0;
    data_in = 8'h3C;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    checkOutput("postResetDone", op_done, 1);
    checkOutput("postResetBusy", busy, 0);
    checkOutput("postResetBusZ", (data_out === 8'hzz), 1);
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    mcarry = 0;
    mzero = 1;
    modelOp(1, 0, 'h3C, 0);
    for (int i = 0; i < 4; i++) begin
      readReg(i, rd);
      checkOutput("postResetReg", rd, mreg[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
